// File: rtl/sweep_scheduler.sv
// Walks writeLoc over the grid once per accepted game tick: LOAD, SETTLE, WRITE, ADVANCE per cell.
// Outputs are Moore-decoded from state or registered; PAUSE and RUN are honoured only between cells.
module sweep_scheduler #(
    parameter int X_bits        = 8,
    parameter int Y_bits        = 7,
    parameter int X_MAX         = 159,
    parameter int Y_MAX         = 119,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic              newLocClock,
    input  logic              RESET_SIM,
    input  logic              RUN,
    input  logic              PAUSE,
    input  logic              game_tick,
    output logic [X_bits-1:0] writeLoc_x,
    output logic [Y_bits-1:0] writeLoc_y,
    output logic              cache_load,
    output logic              write_flag,
    output logic              hold_locs,
    output logic              sweep_busy,
    output logic              sweep_done,
    output logic              tick_overrun,
    output logic [15:0]       sweep_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SETTLE  = 3'd2,
        WRITE   = 3'd3,
        ADVANCE = 3'd4,
        PAUSED  = 3'd5
    } state_t;

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]     SETTLE_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [X_bits-1:0] X_LAST      = X_bits'(X_MAX);
    localparam logic [Y_bits-1:0] Y_LAST      = Y_bits'(Y_MAX);

    state_t            state;
    logic [CW-1:0]     settle_cnt;
    logic [X_bits-1:0] x_next;
    logic [Y_bits-1:0] y_next;
    logic              last_cell;

    assign last_cell = (writeLoc_x == X_LAST) && (writeLoc_y == Y_LAST);

    always_comb begin
        x_next = writeLoc_x + X_bits'(1);
        y_next = writeLoc_y;
        if (writeLoc_x == X_LAST) begin
            x_next = '0;
            y_next = writeLoc_y + Y_bits'(1);
        end
    end

    assign cache_load = (state == LOAD);
    assign write_flag = (state == WRITE);
    assign hold_locs  = (state != ADVANCE);
    assign sweep_busy = (state != IDLE);

    always_ff @(posedge newLocClock) begin
        if (RESET_SIM) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            writeLoc_x   <= '0;
            writeLoc_y   <= '0;
            sweep_done   <= 1'b0;
            tick_overrun <= 1'b0;
            sweep_count  <= '0;
        end else begin
            sweep_done <= 1'b0;
            // Ticks that land mid-sweep are dropped but remembered until reset.
            if (game_tick && (state != IDLE))
                tick_overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (game_tick && RUN && !PAUSE)
                        state <= LOAD;
                end
                LOAD: begin
                    settle_cnt <= '0;
                    if (SETTLE_CYCLES > 0)
                        state <= SETTLE;
                    else
                        state <= WRITE;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST)
                        state <= WRITE;
                    else
                        settle_cnt <= settle_cnt + CW'(1);
                end
                WRITE: begin
                    state <= ADVANCE;
                end
                ADVANCE: begin
                    if (last_cell) begin
                        writeLoc_x  <= '0;
                        writeLoc_y  <= '0;
                        sweep_done  <= 1'b1;
                        sweep_count <= sweep_count + 16'd1;
                        state       <= IDLE;
                    end else if (!RUN) begin
                        writeLoc_x <= '0;
                        writeLoc_y <= '0;
                        state      <= IDLE;
                    end else begin
                        writeLoc_x <= x_next;
                        writeLoc_y <= y_next;
                        state      <= PAUSE ? PAUSED : LOAD;
                    end
                end
                PAUSED: begin
                    if (!RUN) begin
                        writeLoc_x <= '0;
                        writeLoc_y <= '0;
                        state      <= IDLE;
                    end else if (!PAUSE) begin
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_scheduler.sv
// Directed checks of sweep_scheduler on a reduced grid: timing, wrap, pause, abort, overrun, reset.
module tb_sweep_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b1;
    logic       pause = 1'b0;
    logic       tick_a = 1'b0;
    logic       tick_b = 1'b0;

    logic [7:0]  a_x, b_x;
    logic [6:0]  a_y, b_y;
    logic        a_cl, a_wf, a_hold, a_busy, a_done, a_ovr;
    logic        b_cl, b_wf, b_hold, b_busy, b_done, b_ovr;
    logic [15:0] a_cnt, b_cnt;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    // 8x4 grid, settle of 3: 6 cycles per cell, 192 cycles per sweep
    sweep_scheduler #(.X_bits(8), .Y_bits(7), .X_MAX(7), .Y_MAX(3), .SETTLE_CYCLES(3)) u_dut (
        .newLocClock(clk), .RESET_SIM(rst), .RUN(run), .PAUSE(pause), .game_tick(tick_a),
        .writeLoc_x(a_x), .writeLoc_y(a_y), .cache_load(a_cl), .write_flag(a_wf),
        .hold_locs(a_hold), .sweep_busy(a_busy), .sweep_done(a_done),
        .tick_overrun(a_ovr), .sweep_count(a_cnt)
    );

    // 4x2 grid, no settle: 3 cycles per cell
    sweep_scheduler #(.X_bits(8), .Y_bits(7), .X_MAX(3), .Y_MAX(1), .SETTLE_CYCLES(0)) u_dut0 (
        .newLocClock(clk), .RESET_SIM(rst), .RUN(run), .PAUSE(pause), .game_tick(tick_b),
        .writeLoc_x(b_x), .writeLoc_y(b_y), .cache_load(b_cl), .write_flag(b_wf),
        .hold_locs(b_hold), .sweep_busy(b_busy), .sweep_done(b_done),
        .tick_overrun(b_ovr), .sweep_count(b_cnt)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; tick_a = 1'b0; tick_b = 1'b0;
        cyc(2);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wf_total, done_n, done_cyc, viol, wf_c;
        int wt[$];
        int wx[$];
        int wy[$];

        run = 1'b1; pause = 1'b0;
        do_reset();
        check("rst_x", a_x, 0);
        check("rst_y", a_y, 0);
        check("rst_cl", a_cl, 0);
        check("rst_wf", a_wf, 0);
        check("rst_hold", a_hold, 1);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_ovr", a_ovr, 0);
        check("rst_cnt", a_cnt, 0);

        // first-cell timing: tick sampled at edge 0
        tick_a = 1'b1; cyc(1); tick_a = 1'b0;
        check("t1_cl_c1", a_cl, 1);
        check("t1_busy_c1", a_busy, 1);
        viol = 0;
        for (int c = 2; c <= 4; c++) begin
            cyc(1);
            if (a_cl || a_wf) viol++;
        end
        check("t1_quiet_settle", viol, 0);
        cyc(1);
        check("t1_wf_c5", a_wf, 1);
        check("t1_wf_x", a_x, 0);
        cyc(1);
        check("t1_hold_c6", a_hold, 0);
        cyc(1);
        check("t1_x_c7", a_x, 1);
        check("t1_y_c7", a_y, 0);
        check("t1_cl_c7", a_cl, 1);
        check("t1_hold_c7", a_hold, 1);

        wf_total = 1; done_n = 0; done_cyc = -1;
        for (int c = 8; c <= 260; c++) begin
            cyc(1);
            if (a_wf) wf_total++;
            if (a_done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
        check("t1_done_cycle", done_cyc, 193);
        check("t1_done_pulses", done_n, 1);
        check("t1_write_count", wf_total, 32);
        check("t1_sweep_count", a_cnt, 1);
        check("t1_end_x", a_x, 0);
        check("t1_end_y", a_y, 0);
        check("t1_end_busy", a_busy, 0);

        // zero-settle sweep with row wrap
        tick_b = 1'b1; cyc(1); tick_b = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (b_wf) begin
                wt.push_back(c); wx.push_back(int'(b_x)); wy.push_back(int'(b_y));
            end
            cyc(1);
        end
        check("t2_pulses", wt.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_time%0d", i), (i < wt.size()) ? wt[i] : -1, 2 + 3 * i);
            check($sformatf("t2_x%0d", i), (i < wx.size()) ? wx[i] : -1, i % 4);
            check($sformatf("t2_y%0d", i), (i < wy.size()) ? wy[i] : -1, i / 4);
        end
        check("t2_sweep_count", b_cnt, 1);

        // pause raised during WRITE of cell (2,0)
        do_reset();
        tick_a = 1'b1; cyc(1); tick_a = 1'b0;
        cyc(16);
        check("t3_wf_c17", a_wf, 1);
        check("t3_wf_x", a_x, 2);
        pause = 1'b1;
        cyc(2);
        check("t3_paused_x", a_x, 3);
        check("t3_paused_hold", a_hold, 1);
        check("t3_paused_busy", a_busy, 1);
        viol = 0;
        for (int c = 0; c < 50; c++) begin
            cyc(1);
            if (a_cl || a_wf || a_x != 8'd3 || !a_busy) viol++;
        end
        check("t3_pause_quiet", viol, 0);
        pause = 1'b0;
        cyc(1);
        check("t3_resume_cl", a_cl, 1);
        check("t3_resume_x", a_x, 3);
        check("t3_resume_y", a_y, 0);

        // RUN dropped during LOAD of (3,0): cell finishes, then abort
        run = 1'b0;
        wf_c = -1; done_n = 0;
        for (int c = 1; c <= 6; c++) begin
            cyc(1);
            if (a_wf) wf_c = c;
            if (a_done) done_n++;
        end
        check("t4_wf_cycle", wf_c, 4);
        check("t4_no_done", done_n, 0);
        check("t4_busy", a_busy, 0);
        check("t4_x", a_x, 0);
        check("t4_y", a_y, 0);
        check("t4_cnt", a_cnt, 0);

        // tick while paused in IDLE is dropped; tick mid-sweep sets overrun
        run = 1'b1; pause = 1'b1;
        tick_a = 1'b1; cyc(1); tick_a = 1'b0;
        check("t5_idle_pause_busy", a_busy, 0);
        check("t5_idle_pause_cl", a_cl, 0);
        check("t5_idle_pause_ovr", a_ovr, 0);
        pause = 1'b0;
        tick_a = 1'b1; cyc(1); tick_a = 1'b0;
        check("t5_start_cl", a_cl, 1);
        check("t5_ovr_before", a_ovr, 0);
        cyc(9);
        tick_a = 1'b1; cyc(1); tick_a = 1'b0;
        check("t5_ovr_set", a_ovr, 1);
        done_n = 0;
        for (int c = 0; c < 450; c++) begin
            cyc(1);
            if (a_done) done_n++;
        end
        check("t5_done_pulses", done_n, 1);
        check("t5_cnt", a_cnt, 1);
        check("t5_ovr_sticky", a_ovr, 1);
        check("t5_idle_after", a_busy, 0);

        // reset during SETTLE of cell (5,1)
        do_reset();
        tick_a = 1'b1; cyc(1); tick_a = 1'b0;
        cyc(79);
        check("t6_pre_x", a_x, 5);
        check("t6_pre_y", a_y, 1);
        check("t6_pre_busy", a_busy, 1);
        rst = 1'b1;
        cyc(1);
        check("t6_x", a_x, 0);
        check("t6_y", a_y, 0);
        check("t6_cl", a_cl, 0);
        check("t6_wf", a_wf, 0);
        check("t6_hold", a_hold, 1);
        check("t6_busy", a_busy, 0);
        check("t6_done", a_done, 0);
        check("t6_cnt", a_cnt, 0);
        rst = 1'b0;
        viol = 0;
        for (int c = 0; c < 20; c++) begin
            cyc(1);
            if (a_wf || a_busy || a_done) viol++;
        end
        check("t6_no_stray", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
